// File: rtl/fifo_pkg.sv
// Shared sizing helpers and defaults for the FIFO family.
// Pointer width is $clog2(DEPTH); the count is one bit wider so that it can hold DEPTH itself.
package fifo_pkg;

  localparam int DEFAULT_DEPTH = 8;
  localparam int DEFAULT_WIDTH = 32;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/bram.sv
// Simple dual-port block RAM: port A writes (read-first), port B is a registered read port.
// Outputs are not reset; contents persist across controller resets.
module bram
  import fifo_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                          clk,
  input  logic                          wea,
  input  logic [addr_width(DEPTH)-1:0]  addra,
  input  logic [WIDTH-1:0]              dina,
  output logic [WIDTH-1:0]              douta,
  input  logic                          rd,
  input  logic [addr_width(DEPTH)-1:0]  addrb,
  output logic [WIDTH-1:0]              doutb
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wea) begin
      mem[addra] <= dina;
    end
    douta <= mem[addra];
  end

  // Read-first: a port-B read of a slot being written this edge returns the old word.
  always_ff @(posedge clk) begin
    if (rd) begin
      doutb <= mem[addrb];
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO built around a dual-port bram.
// The read address looks one slot ahead on a pop so the RAM output always tracks the head.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic [WIDTH-1:0]               wr_data,
  output logic                           rd_valid,
  input  logic                           rd_ready,
  output logic [WIDTH-1:0]               rd_data,
  output logic [count_width(DEPTH)-1:0]  count,
  output logic                           full,
  output logic                           empty
);

  localparam int AW = addr_width(DEPTH);
  localparam int CW = count_width(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("sync_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_addr;
  logic             push;
  logic             pop;
  logic             rd_valid_nxt;
  logic [WIDTH-1:0] douta_unused;

  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign wr_ready     = !full;
  assign push         = wr_valid && wr_ready;
  assign pop          = rd_valid && rd_ready;
  assign rd_addr      = pop ? rd_ptr + AW'(1) : rd_ptr;
  // A word pushed this edge is not yet readable from the RAM, so only count-pop matters.
  assign rd_valid_nxt = (count - CW'(pop)) != '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      rd_valid <= rd_valid_nxt;
    end
  end

  bram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_bram (
    .clk   (clk),
    .wea   (push),
    .addra (wr_ptr),
    .dina  (wr_data),
    .douta (douta_unused),
    .rd    (1'b1),
    .addrb (rd_addr),
    .doutb (rd_data)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed vector table, corner-case sequences and a
// random run, all backed by a queue scoreboard and a count/rd_valid reference model.
module tb_sync_fifo;

  localparam int DEPTH = 8;
  localparam int WIDTH = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wr_valid;
  logic             wr_ready;
  logic [WIDTH-1:0] wr_data;
  logic             rd_valid;
  logic             rd_ready;
  logic [WIDTH-1:0] rd_data;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wv;
    logic [31:0] wd;
    bit          rr;
    int          exp_count;
    bit          exp_valid;
    bit          exp_empty;
    logic [31:0] exp_data;
    bit          chk_data;
  } vec_t;

  vec_t        vecs [12];
  logic [31:0] sb [$];
  int          mcount;
  bit          mvalid;
  int          checks;
  int          errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Compare the DUT against the reference model state left by the previous edge.
  task automatic checkOutput();
    check("count", 32'(count), 32'(mcount));
    check("rd_valid", 32'(rd_valid), 32'(mvalid));
    check("full", 32'(full), 32'(mcount == DEPTH));
    check("empty", 32'(empty), 32'(mcount == 0));
    check("wr_ready", 32'(wr_ready), 32'(mcount != DEPTH));
    if (mvalid && sb.size() > 0) begin
      check("rd_data", rd_data, sb[0]);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and advance the model for the next rising edge.
  task automatic applyStimulus(input bit wv, input logic [31:0] wd, input bit rr);
    bit mpush;
    bit mpop;
    bit nvalid;
    @(negedge clk);
    checkOutput();
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    mpush  = wv && (mcount != DEPTH);
    mpop   = mvalid && rr;
    nvalid = (mcount - int'(mpop)) > 0;
    if (mpop) begin
      void'(sb.pop_front());
    end
    if (mpush) begin
      sb.push_back(wd);
    end
    mcount = mcount + int'(mpush) - int'(mpop);
    mvalid = nvalid;
  endtask

  task automatic pulseReset();
    rst_n = 1'b0;
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    sb.delete();
    mcount   = 0;
    mvalid   = 1'b0;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 32'hA5A5_0001, 1'b0, 1, 1'b0, 1'b0, 32'h0,         1'b0};
    vecs[1]  = '{1'b0, 32'h0,         1'b0, 1, 1'b1, 1'b0, 32'hA5A5_0001, 1'b1};
    vecs[2]  = '{1'b1, 32'hA5A5_0002, 1'b1, 1, 1'b0, 1'b0, 32'h0,         1'b0};
    vecs[3]  = '{1'b0, 32'h0,         1'b0, 1, 1'b1, 1'b0, 32'hA5A5_0002, 1'b1};
    vecs[4]  = '{1'b1, 32'hA5A5_0003, 1'b0, 2, 1'b1, 1'b0, 32'hA5A5_0002, 1'b1};
    vecs[5]  = '{1'b1, 32'hA5A5_0004, 1'b1, 2, 1'b1, 1'b0, 32'hA5A5_0003, 1'b1};
    vecs[6]  = '{1'b0, 32'h0,         1'b1, 1, 1'b1, 1'b0, 32'hA5A5_0004, 1'b1};
    vecs[7]  = '{1'b0, 32'h0,         1'b1, 0, 1'b0, 1'b1, 32'h0,         1'b0};
    vecs[8]  = '{1'b0, 32'h0,         1'b1, 0, 1'b0, 1'b1, 32'h0,         1'b0};
    vecs[9]  = '{1'b1, 32'hA5A5_0005, 1'b1, 1, 1'b0, 1'b0, 32'h0,         1'b0};
    vecs[10] = '{1'b0, 32'h0,         1'b1, 1, 1'b1, 1'b0, 32'hA5A5_0005, 1'b1};
    vecs[11] = '{1'b0, 32'h0,         1'b1, 0, 1'b0, 1'b1, 32'h0,         1'b0};

    checks   = 0;
    errors   = 0;
    mcount   = 0;
    mvalid   = 1'b0;
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    rd_ready = 1'b0;

    #12;
    check("init_count", 32'(count), 32'd0);
    check("init_rd_valid", 32'(rd_valid), 32'd0);
    check("init_empty", 32'(empty), 32'd1);
    check("init_full", 32'(full), 32'd0);
    check("init_wr_ready", 32'(wr_ready), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    $display("[TB] directed vector table");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].wv, vecs[i].wd, vecs[i].rr);
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
      check($sformatf("tbl%0d_rd_valid", i), 32'(rd_valid), 32'(vecs[i].exp_valid));
      check($sformatf("tbl%0d_empty", i), 32'(empty), 32'(vecs[i].exp_empty));
      if (vecs[i].chk_data) begin
        check($sformatf("tbl%0d_rd_data", i), rd_data, vecs[i].exp_data);
      end
    end

    $display("[TB] fill to full, overflow attempt, drain");
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 32'hF000_0000 + 32'(i), 1'b0);
    end
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0);
    @(posedge clk);
    #1;
    check("fill_full", 32'(full), 32'd1);
    check("fill_wr_ready", 32'(wr_ready), 32'd0);
    check("fill_count", 32'(count), 32'd8);
    check("fill_head", rd_data, 32'hF000_0000);
    for (int i = 0; i < DEPTH + 1; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1);
    end
    @(posedge clk);
    #1;
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_count", 32'(count), 32'd0);

    $display("[TB] continuous streaming across pointer wrap");
    applyStimulus(1'b1, 32'hC000_1000, 1'b0);
    applyStimulus(1'b1, 32'hC000_1001, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 32'hC000_0000 + 32'(i), 1'b1);
      @(posedge clk);
      #1;
      check("stream_count", 32'(count), 32'd2);
      check("stream_rd_valid", 32'(rd_valid), 32'd1);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1);
    end

    $display("[TB] head hold under back-pressure");
    applyStimulus(1'b1, 32'h1234_5678, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 32'h5500_0000 + 32'(i), 1'b0);
      @(posedge clk);
      #1;
      check("hold_rd_data", rd_data, 32'h1234_5678);
      check("hold_rd_valid", 32'(rd_valid), 32'd1);
    end
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1);
    end

    $display("[TB] asynchronous reset mid-stream");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 32'hB000_0000 + 32'(i), 1'b0);
    end
    applyStimulus(1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #3;
    check("prerst_count", 32'(count), 32'd5);
    pulseReset();
    applyStimulus(1'b1, 32'hA5A5_0001, 1'b0);
    @(posedge clk);
    #1;
    check("postrst_bubble_valid", 32'(rd_valid), 32'd0);
    check("postrst_count", 32'(count), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    check("postrst_rd_valid", 32'(rd_valid), 32'd1);
    check("postrst_rd_data", rd_data, 32'hA5A5_0001);

    $display("[TB] random traffic");
    for (int i = 0; i < 10000; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 32'($urandom), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < DEPTH + 4; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1);
    end
    @(negedge clk);
    checkOutput();
    check("final_empty", 32'(empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001: The module SHALL have parameter DEPTH, default 8, giving the number of entries; it must be a power of two and at least 2.
REQ-002: The module SHALL have parameter WIDTH, default 32, giving the data word width in bits.
REQ-003: clk  input  1  single clock; all state updates on its rising edge.
REQ-004: rst_n  input  1  reset, asynchronous, active-low.
REQ-005: wr_valid  input  1  the writer offers wr_data this cycle.
REQ-006: wr_ready  output  1  the FIFO can accept a word this cycle.
REQ-007: wr_data  input  WIDTH  write word.
REQ-008: rd_valid  output  1  rd_data holds the oldest stored word.
REQ-009: rd_ready  input  1  the reader consumes rd_data this cycle.
REQ-010: rd_data  output  WIDTH  oldest word, first-word-fall-through.
REQ-011: count  output  $clog2(DEPTH)+1  number of stored words, 0..DEPTH.
REQ-012: full / empty  output  1 each  count==DEPTH / count==0.

Function
REQ-013: A push SHALL occur on an edge where wr_valid && wr_ready; a pop SHALL occur on an edge where rd_valid && rd_ready.
REQ-014: wr_ready SHALL equal !full, combinationally from registered state; it is not gated by rd_ready, so there is no write-through at full.
REQ-015: A push SHALL write wr_data to the storage RAM at wr_ptr; wr_ptr increments modulo DEPTH.
REQ-016: A pop SHALL advance rd_ptr modulo DEPTH.
REQ-017: count SHALL update as follows: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop or on neither.
REQ-018: The RAM read address SHALL be rd_ptr+1 (mod DEPTH) on a pop edge and rd_ptr otherwise, so that the RAM output always tracks the head entry.
REQ-019: rd_data SHALL be driven directly from the RAM registered read port; the read latency is 1 cycle.
REQ-020: The next value of rd_valid SHALL be (count - pop) > 0, evaluated before the current push is counted.
REQ-021: A word pushed into an empty FIFO at edge E0 SHALL appear with rd_valid=1 after edge E1, i.e. a 1-cycle bubble.
REQ-022: While rd_valid=1 and rd_ready=0, rd_data SHALL hold stable, because the head slot is never overwritten while occupied.
REQ-023: Simultaneous push and pop at count==1 SHALL present the new word after the next edge, keeping rd_valid high only if count-pop>0 permits; otherwise rd_valid drops for exactly 1 cycle.
REQ-024: Pointer wrap from DEPTH-1 to 0 SHALL be seamless; order is preserved across wrap.
REQ-025: When full, wr_valid SHALL be ignored with no state change; when empty, rd_ready SHALL be ignored.
REQ-026: rd_data content while rd_valid=0 SHALL be don't-care.

Reset
REQ-027: Assertion of rst_n=0 SHALL immediately force wr_ptr=0, rd_ptr=0, count=0, rd_valid=0, empty=1, full=0 and wr_ready=1.
REQ-028: Reset mid-operation SHALL discard all stored words; RAM contents are not cleared and the RAM output is not reset.
REQ-029: After deassertion, a push SHALL be accepted on the first rising edge of clk.

Structure
REQ-030: Package fifo_pkg SHALL hold the helper for address width ($clog2(DEPTH)) and count width, shared with future FIFO variants.
REQ-031: Storage SHALL be a single instance of the existing dual-port bram sub-module.
REQ-032: The bram port connections SHALL be:
- port A is the write port: wea=push, addra=wr_ptr, dina=wr_data; douta is unused.
- port B is the read port: addrb per REQ-018; rd tied high.
REQ-033: The controller SHALL contain no other storage arrays.

Verification
REQ-034: Reset, then push 0xA5A5_0001 -> rd_valid rises exactly 1 edge after acceptance, rd_data=0xA5A5_0001 and count=1.
REQ-035: With DEPTH=8, push 8 words with rd_ready=0 -> full=1, wr_ready=0 and count=8; a 9th write is ignored; the reader then drains 8 words in order and empty=1.
REQ-036: Continuous push and pop for 20 words (ptr wrap twice) -> output sequence identical to input and count stays constant.
REQ-037: Hold rd_ready=0 for 5 cycles with rd_valid=1 while pushing -> rd_data stable throughout.
REQ-038: Drive rst_n low mid-stream at count=5 -> count=0, rd_valid=0 and empty=1 asynchronously; next push appears per REQ-021.
REQ-039: Random wr_valid/rd_ready at 50% each, 10k cycles -> scoreboard match, no push when full, no pop when empty.
